// File: rtl/dds_pkg.sv
// Shared types and scale constants for the DDS waveform generator.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Offset-binary zero level of an out_w-bit sample.
  function automatic int unsigned midscale(int unsigned out_w);
    return 32'd1 << (out_w - 32'd1);
  endfunction

  function automatic int unsigned fullscale(int unsigned out_w);
    return (32'd1 << out_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine magnitude ROM, sampled at bin centres so the
// mirrored quadrants meet without a repeated peak or zero entry.
module sine_quarter_lut #(
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned LUT_AW = 6
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data_c
);

  localparam int unsigned DEPTH = 32'd1 << LUT_AW;

  function automatic logic [OUT_W-2:0] lut_entry(int idx);
    real amp;
    real ang;
    amp = real'((32'd1 << (OUT_W - 32'd1)) - 32'd1);
    ang = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(DEPTH);
    return (OUT_W-1)'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-2:0] rom [DEPTH];

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
    localparam logic [OUT_W-2:0] ENTRY = lut_entry(i);
    assign rom[i] = ENTRY;
  end

  assign data_c = rom[addr];

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform core: phase accumulator, config staging FSM and a
// two-stage sample pipeline producing offset-binary DAC words.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned LUT_AW  = 6
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [1:0]         cfg_wave,
  input  logic [OUT_W-1:0]   cfg_duty,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               cycle_start
);

  localparam logic [OUT_W-1:0] MID  = OUT_W'(midscale(OUT_W));
  localparam logic [OUT_W-1:0] FULL = OUT_W'(fullscale(OUT_W));

  state_t               state_q, state_d;
  logic                 ld_cfg, ld_pend, apply_pend;
  logic                 cfg_hs;
  logic [PHASE_W-1:0]   phase_q, phase_sum;
  logic                 carry, phase_start_q;
  logic [PHASE_W-1:0]   act_ftw, pend_ftw;
  wave_t                act_wave, pend_wave;
  logic [OUT_W-1:0]     act_duty, pend_duty;

  logic [OUT_W-1:0]     pt, tri_t, s1_val_d;
  logic [1:0]           quad;
  logic [LUT_AW-1:0]    lut_a;
  logic                 s1_valid, s1_start, s1_sine, s1_neg;
  logic [LUT_AW-1:0]    s1_addr;
  logic [OUT_W-1:0]     s1_val;
  logic [OUT_W-2:0]     lut_v;
  logic [OUT_W-1:0]     sine_val;

  assign cfg_hs             = cfg_valid && cfg_ready;
  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, act_ftw};

  // Config staging: direct load when idle, otherwise hold until a wrap.
  always_comb begin
    state_d    = state_q;
    ld_cfg     = 1'b0;
    ld_pend    = 1'b0;
    apply_pend = 1'b0;
    case (state_q)
      IDLE: begin
        ld_cfg = cfg_hs;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          ld_cfg  = cfg_hs;
          state_d = IDLE;
        end else if (cfg_hs) begin
          ld_pend = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!enable) begin
          apply_pend = 1'b1;
          state_d    = IDLE;
        end else if (carry || act_ftw == '0) begin
          apply_pend = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cfg_ready <= (state_d != PEND);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      act_ftw   <= '0;
      act_wave  <= WAVE_SINE;
      act_duty  <= '0;
      pend_ftw  <= '0;
      pend_wave <= WAVE_SINE;
      pend_duty <= '0;
    end else begin
      if (ld_cfg) begin
        act_ftw  <= cfg_ftw;
        act_wave <= wave_t'(cfg_wave);
        act_duty <= cfg_duty;
      end else if (apply_pend) begin
        act_ftw  <= pend_ftw;
        act_wave <= pend_wave;
        act_duty <= pend_duty;
      end
      if (ld_pend) begin
        pend_ftw  <= cfg_ftw;
        pend_wave <= wave_t'(cfg_wave);
        pend_duty <= cfg_duty;
      end
    end
  end

  // Residual phase is kept across a wrap; the flag marks a cycle-start phase.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= '0;
      phase_start_q <= 1'b1;
    end else if (!enable) begin
      phase_q       <= '0;
      phase_start_q <= 1'b1;
    end else begin
      phase_q       <= phase_sum;
      phase_start_q <= carry;
    end
  end

  assign pt    = phase_q[PHASE_W-1 -: OUT_W];
  assign tri_t = phase_q[PHASE_W-2 -: OUT_W];
  assign quad  = phase_q[PHASE_W-1 -: 2];
  assign lut_a = phase_q[PHASE_W-3 -: LUT_AW];

  always_comb begin
    s1_val_d = pt;
    case (act_wave)
      WAVE_SQUARE: s1_val_d = (pt < act_duty) ? FULL : '0;
      WAVE_TRI:    s1_val_d = quad[1] ? ~tri_t : tri_t;
      default:     s1_val_d = pt;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_sine  <= 1'b0;
      s1_neg   <= 1'b0;
      s1_addr  <= '0;
      s1_val   <= '0;
    end else begin
      s1_valid <= enable;
      s1_start <= enable && phase_start_q;
      s1_sine  <= (act_wave == WAVE_SINE);
      s1_neg   <= quad[1];
      s1_addr  <= quad[0] ? ~lut_a : lut_a;
      s1_val   <= s1_val_d;
    end
  end

  sine_quarter_lut #(
    .OUT_W  (OUT_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .addr   (s1_addr),
    .data_c (lut_v)
  );

  // Upper half mid+v is {1,v}; lower half mid-1-v is {0,~v}.
  assign sine_val = s1_neg ? {1'b0, ~lut_v} : {1'b1, lut_v};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sample_out   <= MID;
      sample_valid <= 1'b0;
      cycle_start  <= 1'b0;
    end else if (!enable || !s1_valid) begin
      sample_out   <= MID;
      sample_valid <= 1'b0;
      cycle_start  <= 1'b0;
    end else begin
      sample_out   <= s1_sine ? sine_val : s1_val;
      sample_valid <= 1'b1;
      cycle_start  <= s1_start;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: an integer phase/config model predicts
// each sample; a negedge monitor pops and compares whenever sample_valid is high.
module tb_dds_wave_gen;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned LUT_AW  = 6;
  localparam int unsigned PH_MOD  = 32'd1 << PHASE_W;

  logic        clk_in = 1'b0;
  logic        reset_n, enable, cfg_valid, cfg_ready;
  logic [23:0] cfg_ftw;
  logic [1:0]  cfg_wave;
  logic [7:0]  cfg_duty, sample_out;
  logic        sample_valid, cycle_start;

  dds_wave_gen #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ftw(cfg_ftw),
    .cfg_wave(cfg_wave), .cfg_duty(cfg_duty), .sample_out(sample_out),
    .sample_valid(sample_valid), .cycle_start(cycle_start)
  );

  always #40 clk_in = ~clk_in;

  typedef struct { int samp; bit st; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;

  int unsigned m_phase, m_ftw, m_wave, m_duty, p_ftw, p_wave, p_duty;
  bit m_start, m_prev_en, p_v;

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference sample straight from the waveform definitions.
  function automatic int exp_sample(int unsigned ph, int unsigned wave, int unsigned duty);
    int unsigned pt = ph >> 16;
    int unsigned t  = (ph >> 15) & 255;
    int unsigned q  = ph >> 22;
    int unsigned a  = (ph >> 16) & 63;
    int v;
    case (wave)
      3: return int'(pt);
      1: return (pt < duty) ? 255 : 0;
      2: return (ph >= 32'h800000) ? 255 - int'(t) : int'(t);
      default: begin
        if (q % 2 == 1) a = 63 - a;
        v = $rtoi(127.0 * $sin(3.14159265358979 / 2.0 * (real'(a) + 0.5) / 64.0) + 0.5);
        return (q < 2) ? 128 + v : 127 - v;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_start = 1; m_prev_en = 0;
    m_ftw = 0; m_wave = 0; m_duty = 0;
    p_v = 0; p_ftw = 0; p_wave = 0; p_duty = 0;
  endtask

  task automatic load_active();
    m_ftw = cfg_ftw; m_wave = cfg_wave; m_duty = cfg_duty;
  endtask

  task automatic apply_pending();
    m_ftw = p_ftw; m_wave = p_wave; m_duty = p_duty; p_v = 0;
  endtask

  // Advance the model by one clock using the inputs present at this edge.
  task automatic model_edge();
    bit hs;
    bit wrap;
    int unsigned nxt;
    hs = cfg_valid && !p_v;
    if (enable) begin
      exp_q.push_back('{samp: exp_sample(m_phase, m_wave, m_duty), st: m_start});
      nxt = m_phase + m_ftw;
      wrap = (nxt >= PH_MOD);
      m_phase = nxt % PH_MOD;
      m_start = wrap;
      if (!m_prev_en) begin
        if (hs) load_active();
      end else begin
        if (p_v && (wrap || m_ftw == 0)) apply_pending();
        if (hs) begin
          p_ftw = cfg_ftw; p_wave = cfg_wave; p_duty = cfg_duty; p_v = 1;
        end
      end
    end else begin
      // The sample still in the pipeline is flushed, never presented.
      if (m_prev_en && exp_q.size() > 0) void'(exp_q.pop_back());
      if (p_v) apply_pending();
      else if (hs) load_active();
      m_phase = 0;
      m_start = 1;
    end
    m_prev_en = enable;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
    check("cfg_ready", cfg_ready, !p_v);
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic configure(int wave, int unsigned ftw, int duty);
    cfg_valid = 1'b1;
    cfg_wave  = 2'(wave);
    cfg_ftw   = 24'(ftw);
    cfg_duty  = 8'(duty);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic stop_run();
    enable    = 1'b0;
    cfg_valid = 1'b0;
    tick();
    check("idle_out", sample_out, 128);
    check("idle_valid", sample_valid, 0);
    check("idle_start", cycle_start, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  function automatic int unsigned rand_ftw();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return $urandom_range(1, 32'h3FFFF);
      default: return $urandom & 32'hFFFFFF;
    endcase
  endfunction

  always @(negedge clk_in) begin
    if (reset_n && sample_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got %0d expected none at %0t", sample_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sample", sample_out, mon_e.samp);
        check("cycle_start", cycle_start, mon_e.st);
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_ftw = '0; cfg_wave = '0; cfg_duty = '0;
    model_reset();
    #100;
    check("rst_out", sample_out, 128);
    check("rst_valid", sample_valid, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_start", cycle_start, 0);
    @(posedge clk_in);
    #1 reset_n = 1'b1;

    // Sawtooth with explicit first-sample latency.
    configure(3, 32'h100000, 0);
    enable = 1'b1;
    tick();
    check("lat_valid_1", sample_valid, 0);
    tick();
    check("lat_valid_2", sample_valid, 1);
    check("lat_first_out", sample_out, 0);
    check("lat_first_start", cycle_start, 1);
    run(38);
    stop_run();

    configure(1, 32'h100000, 32'h40);
    enable = 1'b1;
    run(40);
    stop_run();

    configure(2, 32'h080000, 0);
    enable = 1'b1;
    run(70);
    stop_run();

    configure(0, 32'h400000, 0);
    enable = 1'b1;
    run(20);
    stop_run();

    // Frequency change while running applies at the next wrap.
    configure(3, 32'h100000, 0);
    enable = 1'b1;
    run(6);
    configure(3, 32'h200000, 0);
    check("ready_low_after_accept", cfg_ready, 0);
    run(40);
    stop_run();

    // Zero tuning word: pending applies without waiting for a wrap.
    configure(3, 0, 0);
    enable = 1'b1;
    run(3);
    configure(3, 32'h100000, 0);
    run(40);
    stop_run();

    for (int s = 0; s < 25; s++) begin
      int n;
      configure($urandom_range(0, 3), rand_ftw(), $urandom_range(0, 255));
      enable = 1'b1;
      n = $urandom_range(5, 60);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          cfg_valid = 1'b1;
          cfg_wave  = 2'($urandom_range(0, 3));
          cfg_ftw   = 24'(rand_ftw());
          cfg_duty  = 8'($urandom_range(0, 255));
        end else begin
          cfg_valid = 1'b0;
        end
        tick();
      end
      stop_run();
    end

    // Reset mid-run with a config pending: everything returns to reset values.
    configure(3, 32'h100000, 0);
    enable = 1'b1;
    run(5);
    configure(2, 32'h200000, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out", sample_out, 128);
    check("midrst_valid", sample_valid, 0);
    check("midrst_ready", cfg_ready, 1);
    check("midrst_start", cycle_start, 0);
    exp_q.delete();
    model_reset();
    @(posedge clk_in);
    #1 reset_n = 1'b1;
    run(6);
    stop_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
- Direct-digital-synthesis waveform core. Sits downstream of the 50 MHz→12.5 MHz clock divider; clk_in is that divided 12.5 MHz clock.
- Generates sine, square, triangle or sawtooth samples from a phase accumulator. Each sample is an unsigned offset-binary word for the output DAC stage.
- Frequency, waveform and duty are reconfigured through a valid/ready port. Changes take effect glitch-free at the next phase wrap.

Parameters:
- PHASE_W, 24, phase accumulator and tuning word width.
- OUT_W, 8, sample width; midscale = 2^(OUT_W-1).
- LUT_AW, 6, quarter-wave sine LUT address bits (2^LUT_AW entries).

Ports:
- clk_in  in  1  sample clock (12.5 MHz from divider).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run generator; low = idle, phase held at 0.
- cfg_valid  in  1  config word offered.
- cfg_ready  out  1  config slot free.
- cfg_ftw  in  PHASE_W  frequency tuning word (phase increment per clk_in).
- cfg_wave  in  2  0=sine, 1=square, 2=triangle, 3=sawtooth.
- cfg_duty  in  OUT_W  square high threshold.
- sample_out  out  OUT_W  waveform sample, unsigned.
- sample_valid  out  1  sample_out is a live sample.
- cycle_start  out  1  one-cycle pulse aligned with the sample at phase wrap/start.

Behaviour:
- Reset state (async):
  - phase=0; active ftw/wave/duty=0.
  - pending empty; state IDLE.
  - sample_out=midscale (128 at OUT_W=8); sample_valid=0; cycle_start=0; cfg_ready=1.
- States:
  - IDLE: enable=0.
  - RUN: enable=1, no pending config.
  - PEND: enable=1, config held in pending.
- Transitions:
  - IDLE→RUN on enable=1.
  - RUN→PEND on cfg handshake (cfg_valid&&cfg_ready).
  - PEND→RUN at wrap, when pending loads into active.
  - Any state→IDLE on enable=0.
- Handshake and config rules:
  - cfg_ready=1 in IDLE and RUN; 0 in PEND.
  - In IDLE, an accepted config loads active directly on the next cycle.
  - Accept coincident with a wrap: config goes to pending and applies at the following wrap.
  - Active ftw==0 in PEND: pending applies on the next cycle, since no wrap will occur.
- Accumulator:
  - phase_next = phase + ftw, modulo 2^PHASE_W.
  - Wrap = carry out of that addition.
  - At wrap, the residual phase is kept; no reset of phase.
  - The new ftw is used from the next accumulation.
  - The new wave/duty is used for the sample computed from the wrapped phase.
- Pipeline (2-cycle latency, phase register → stage1 → stage2):
  - Stage1 registers: wave select, quadrant, LUT address / slice, valid, wrap flag.
  - Stage2 registers sample_out, sample_valid and cycle_start.
- Enable:
  - Rising: phase starts at 0; first sample_valid=1 two cycles later, carrying the phase-0 sample with cycle_start=1.
  - Falling: next cycle sample_valid=0, sample_out=midscale, cycle_start=0, pipeline flushed, phase=0.
- Waveform math (Pt = top OUT_W bits of phase):
  - Sawtooth: sample = Pt.
  - Square: sample = (Pt < duty) ? 2^OUT_W-1 : 0. duty=0 gives always 0.
  - Triangle:
    - t = phase[PHASE_W-2 -: OUT_W].
    - sample = phase MSB ? ~t : t.
  - Sine:
    - quadrant = phase[PHASE_W-1:PHASE_W-2]; a = phase[PHASE_W-3 -: LUT_AW].
    - LUT address = a for quadrants 0 and 2, ~a for quadrants 1 and 3.
    - Quadrants 0/1: sample = mid + v. Quadrants 2/3: sample = mid - 1 - v.
- Reset mid-operation: immediately returns all state to the reset values; any pending config is discarded.

Decomposition:
- Package dds_pkg holds:
  - wave_t enum (WAVE_SINE=0, WAVE_SQUARE=1, WAVE_TRI=2, WAVE_SAW=3).
  - state_t enum (IDLE, RUN, PEND).
  - Midscale and full-scale constant functions of OUT_W.
- Sub-module sine_quarter_lut: combinational ROM, 2^LUT_AW entries of OUT_W-1 bits.
  - Entry i = round((2^(OUT_W-1)-1)·sin(π/2·(i+0.5)/2^LUT_AW)).
- Accumulator, FSM and pipeline stay in dds_wave_gen.

Test Plan (PHASE_W=24, OUT_W=8, LUT_AW=6):
- Reset, enable=0 → sample_out=128, sample_valid=0, cfg_ready=1. Assert reset_n low mid-run → same values immediately.
- IDLE config: saw, ftw=0x100000; then enable=1 → valid 2 cycles later with 0x00,0x10,…,0xF0,0x00. cycle_start on every 0x00 (period 16).
- Square, duty=0x40, ftw=0x100000 → repeating 4×0xFF then 12×0x00.
- Triangle, ftw=0x080000 → 0x00,0x10,…,0xF0, then 0xFF,0xEF,…,0x0F; period 32.
- Sine, ftw=0x400000 → repeating 130, 255, 125, 0.
- Running saw ftw=0x100000: push ftw=0x200000 at the 5th sample:
  - cfg_ready drops and step stays 0x10 until wrap.
  - After the wrap sample 0x00 (cycle_start), step becomes 0x20.
  - cfg_ready returns to 1 the cycle after apply.
